// File: rtl/asc_chan_sched_if.sv
// Bundle between the per-channel codec front ends, the scheduler and the shared
// speed-control datapath: request/result handshakes plus datapath operands and results.
interface asc_chan_sched_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
);
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*22-1:0] req_data;
    logic [NCH-1:0]    ctx_clr;

    logic [4:0]  dp_i;
    logic [12:0] dp_y;
    logic        dp_tdp;
    logic        dp_tr;
    logic [1:0]  dp_rate;
    logic [11:0] dp_dms;
    logic [13:0] dp_dml;
    logic [9:0]  dp_ap;
    logic [11:0] dp_dmsp;
    logic [13:0] dp_dmlp;
    logic [9:0]  dp_apr;
    logic [6:0]  dp_al;

    logic           res_valid;
    logic [CHW-1:0] res_ch;
    logic [6:0]     res_al;
    logic           res_ready;

    modport slave (
        input  req_valid, req_data, ctx_clr, res_ready,
        input  dp_dmsp, dp_dmlp, dp_apr, dp_al,
        output req_ready, res_valid, res_ch, res_al,
        output dp_i, dp_y, dp_tdp, dp_tr, dp_rate, dp_dms, dp_dml, dp_ap
    );

    modport master (
        output req_valid, req_data, ctx_clr, res_ready,
        output dp_dmsp, dp_dmlp, dp_apr, dp_al,
        input  req_ready, res_valid, res_ch, res_al,
        input  dp_i, dp_y, dp_tdp, dp_tr, dp_rate, dp_dms, dp_dml, dp_ap
    );
endinterface

// File: rtl/asc_chan_sched.sv
// Round-robin scheduler sharing one adaptive-speed-control datapath among NCH channels,
// holding per-channel DMS/DML/AP context and returning AL tagged with the channel.
module asc_chan_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    asc_chan_sched_if.slave      bus,
    output logic                 busy
);
    localparam int unsigned RW   = 22;
    localparam int unsigned DMSW = 12;
    localparam int unsigned DMLW = 14;
    localparam int unsigned APW  = 10;
    localparam int unsigned ALW  = 7;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, STORE, DONE} state_t;

    state_t state, state_next;

    logic [CHW-1:0]  rr_ptr;
    logic [CHW-1:0]  cur_ch;
    logic            clr_hit;
    logic [CHW-1:0]  grant_c;
    logic            grant_vld_c;
    logic [CHW-1:0]  idx_c;
    logic [RW-1:0]   gdata_c;

    logic [DMSW-1:0] ctx_dms [NCH];
    logic [DMLW-1:0] ctx_dml [NCH];
    logic [APW-1:0]  ctx_ap  [NCH];

    logic [DMSW-1:0] s_dmsp;
    logic [DMLW-1:0] s_dmlp;
    logic [APW-1:0]  s_apr;
    logic [ALW-1:0]  s_al;

    // Round-robin search starting one past the last grant, then next-state decode.
    always_comb begin
        state_next  = state;
        grant_vld_c = 1'b0;
        grant_c     = '0;
        idx_c       = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            idx_c = CHW'((32'(rr_ptr) + 32'(i)) % NCH);
            if (!grant_vld_c && bus.req_valid[idx_c]) begin
                grant_vld_c = 1'b1;
                grant_c     = idx_c;
            end
        end
        gdata_c = bus.req_data[RW*grant_c +: RW];
        case (state)
            IDLE:    if (grant_vld_c) state_next = LOAD;
            LOAD:    state_next = CALC;
            CALC:    state_next = STORE;
            STORE:   state_next = DONE;
            DONE:    if (bus.res_valid && bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Grant capture, operand launch, result sampling and result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= CHW'(NCH - 1);
            cur_ch        <= '0;
            clr_hit       <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= '0;
            bus.dp_i      <= '0;
            bus.dp_y      <= '0;
            bus.dp_tdp    <= 1'b0;
            bus.dp_tr     <= 1'b0;
            bus.dp_rate   <= '0;
            bus.dp_dms    <= '0;
            bus.dp_dml    <= '0;
            bus.dp_ap     <= '0;
            s_dmsp        <= '0;
            s_dmlp        <= '0;
            s_apr         <= '0;
            s_al          <= '0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_al    <= '0;
        end else begin
            busy          <= (state_next != IDLE);
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (grant_vld_c) begin
                        bus.req_ready <= NCH'(1) << grant_c;
                        cur_ch        <= grant_c;
                        rr_ptr        <= grant_c;
                        clr_hit       <= 1'b0;
                        bus.dp_i      <= gdata_c[21:17];
                        bus.dp_y      <= gdata_c[16:4];
                        bus.dp_tdp    <= gdata_c[3];
                        bus.dp_tr     <= gdata_c[2];
                        bus.dp_rate   <= gdata_c[1:0];
                        // A clear landing on the grant edge must not leak stale context.
                        bus.dp_dms    <= bus.ctx_clr[grant_c] ? '0 : ctx_dms[grant_c];
                        bus.dp_dml    <= bus.ctx_clr[grant_c] ? '0 : ctx_dml[grant_c];
                        bus.dp_ap     <= bus.ctx_clr[grant_c] ? '0 : ctx_ap[grant_c];
                    end
                end
                LOAD: begin
                    if (bus.ctx_clr[cur_ch]) clr_hit <= 1'b1;
                end
                CALC: begin
                    if (bus.ctx_clr[cur_ch]) clr_hit <= 1'b1;
                    s_dmsp <= bus.dp_dmsp;
                    s_dmlp <= bus.dp_dmlp;
                    s_apr  <= bus.dp_apr;
                    s_al   <= bus.dp_al;
                end
                STORE: begin
                    bus.res_valid <= 1'b1;
                    bus.res_ch    <= cur_ch;
                    bus.res_al    <= s_al;
                end
                DONE: begin
                    if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Context file: a clear always beats the in-flight write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NCH); k++) begin
                ctx_dms[k] <= '0;
                ctx_dml[k] <= '0;
                ctx_ap[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (bus.ctx_clr[k]) begin
                    ctx_dms[k] <= '0;
                    ctx_dml[k] <= '0;
                    ctx_ap[k]  <= '0;
                end else if (state == STORE && !clr_hit && cur_ch == CHW'(k)) begin
                    ctx_dms[k] <= s_dmsp;
                    ctx_dml[k] <= s_dmlp;
                    ctx_ap[k]  <= s_apr;
                end
            end
        end
    end
endmodule

// File: tb/tb_asc_chan_sched.sv
// Scoreboard bench for asc_chan_sched: expected results are queued at grant time and
// checked when the result handshake completes, with a programmable datapath stub.
module tb_asc_chan_sched;
    localparam int unsigned NCH = 4;
    localparam int unsigned CHW = 2;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [6:0]     al;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    asc_chan_sched_if #(.NCH(NCH), .CHW(CHW)) bus ();

    asc_chan_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q [$];
    int   vectors = 0;
    int   errors  = 0;

    // Datapath stub: mode 0 returns fixed values, mode 1 accumulates on the context.
    int          stub_mode = 0;
    logic [11:0] stub_dmsp = 12'h123;
    logic [13:0] stub_dmlp = 14'h0456;
    logic [9:0]  stub_apr  = 10'h07F;
    logic [6:0]  stub_al   = 7'h15;

    always_comb begin
        if (stub_mode == 1) begin
            bus.dp_dmsp = bus.dp_dms + 12'd1;
            bus.dp_dmlp = bus.dp_dml + 14'd2;
            bus.dp_apr  = bus.dp_ap + 10'd16;
            bus.dp_al   = bus.dp_ap[9:3];
        end else begin
            bus.dp_dmsp = stub_dmsp;
            bus.dp_dmlp = stub_dmlp;
            bus.dp_apr  = stub_apr;
            bus.dp_al   = stub_al;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.ctx_clr   = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    function automatic exp_t mk(input int ch, input logic [6:0] al);
        exp_t e;
        e.ch = CHW'(ch);
        e.al = al;
        return e;
    endfunction

    // Waits (bounded) for a result handshake and compares against the scoreboard head.
    task automatic wait_result(input string name);
        exp_t e;
        bit   done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                done = 1'b1;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: unexpected result ch=%0d al=%h, scoreboard empty", name, bus.res_ch, bus.res_al);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_ch !== e.ch || bus.res_al !== e.al) begin
                        errors++;
                        $display("FAIL %s: got ch=%0d al=%h, want ch=%0d al=%h", name, bus.res_ch, bus.res_al, e.ch, e.al);
                    end
                end
            end
            tick();
        end
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL %s: result timeout", name);
        end
    endtask

    // Issues one request from IDLE, checks the grant and optionally the loaded context.
    task automatic run_txn(input string name, input logic [NCH-1:0] mask, input int exp_ch,
                           input logic [6:0] exp_al, input bit chk_ctx,
                           input logic [11:0] e_dms, input logic [13:0] e_dml, input logic [9:0] e_ap);
        logic [NCH-1:0] want;
        want          = NCH'(1) << exp_ch;
        bus.req_valid = mask;
        tick();
        bus.req_valid = '0;
        vectors++;
        if (bus.req_ready !== want) begin
            errors++;
            $display("FAIL %s grant: got %b want %b", name, bus.req_ready, want);
        end
        if (chk_ctx) begin
            vectors++;
            if (bus.dp_dms !== e_dms || bus.dp_dml !== e_dml || bus.dp_ap !== e_ap) begin
                errors++;
                $display("FAIL %s ctx: got dms=%h dml=%h ap=%h want dms=%h dml=%h ap=%h",
                         name, bus.dp_dms, bus.dp_dml, bus.dp_ap, e_dms, e_dml, e_ap);
            end
        end
        exp_q.push_back(mk(exp_ch, exp_al));
        wait_result(name);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.req_ready !== '0 || bus.dp_ap !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b res_valid=%b req_ready=%b dp_ap=%h want 0", busy, bus.res_valid, bus.req_ready, bus.dp_ap);
        end
    endtask

    task automatic test_single();
        bus.req_data             = '0;
        bus.req_data[2*22 +: 22] = {5'h0F, 13'h0ABC, 1'b1, 1'b0, 2'b10};
        bus.req_valid            = 4'b0100;
        tick();
        bus.req_valid = '0;
        vectors++;
        if (bus.req_ready !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single grant: req_ready=%b busy=%b want 0100 1", bus.req_ready, busy);
        end
        vectors++;
        if (bus.dp_i !== 5'h0F || bus.dp_y !== 13'h0ABC || bus.dp_tdp !== 1'b1 || bus.dp_rate !== 2'b10 || bus.dp_ap !== '0) begin
            errors++;
            $display("FAIL single operands: i=%h y=%h tdp=%b rate=%b ap=%h", bus.dp_i, bus.dp_y, bus.dp_tdp, bus.dp_rate, bus.dp_ap);
        end
        exp_q.push_back(mk(2, 7'h15));
        tick();
        tick();
        vectors++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single early res_valid: got %b want 0", bus.res_valid);
        end
        tick();
        vectors++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL single latency: res_valid at cycle 3 got %b want 1", bus.res_valid);
        end
        wait_result("single result");
        run_txn("single reload", 4'b0100, 2, 7'h15, 1'b1, 12'h123, 14'h0456, 10'h07F);
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int n = 0;
        int last = 0;
        exp_t e;
        do_reset();
        bus.req_valid = 4'b1111;
        for (int cyc = 0; cyc < 60 && (n < 6 || exp_q.size() != 0); cyc++) begin
            tick();
            if (bus.req_ready !== '0) begin
                vectors++;
                if (n >= 6 || bus.req_ready !== (NCH'(1) << order[n])) begin
                    errors++;
                    $display("FAIL rr grant %0d: got %b", n, bus.req_ready);
                end else if (n > 0 && cyc - last != 5) begin
                    errors++;
                    $display("FAIL rr spacing %0d: got %0d want 5", n, cyc - last);
                end
                if (n < 6) exp_q.push_back(mk(order[n], 7'h15));
                last = cyc;
                n++;
                if (n == 6) bus.req_valid = '0;
            end
            if (bus.res_valid === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.res_ch !== e.ch || bus.res_al !== e.al) begin
                    errors++;
                    $display("FAIL rr result: got ch=%0d al=%h want ch=%0d al=%h", bus.res_ch, bus.res_al, e.ch, e.al);
                end
            end
        end
        vectors++;
        if (n != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr count: grants=%0d want 6, pending=%0d want 0", n, exp_q.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0010;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp grant: got %b want 0010", bus.req_ready);
        end
        bus.req_valid = 4'b0011;
        exp_q.push_back(mk(1, 7'h15));
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = (bus.res_valid === 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.res_valid !== 1'b1 || bus.res_ch !== 2'd1 || bus.res_al !== 7'h15 || bus.req_ready !== '0) begin
                errors++;
                $display("FAIL bp hold %0d: res_valid=%b ch=%0d al=%h req_ready=%b", i, bus.res_valid, bus.res_ch, bus.res_al, bus.req_ready);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        wait_result("bp result");
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.req_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp idle: res_valid=%b req_ready=%b busy=%b want 0", bus.res_valid, bus.req_ready, busy);
        end
        tick();
        bus.req_valid = '0;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp next grant: got %b want 0001", bus.req_ready);
        end
        exp_q.push_back(mk(0, 7'h15));
        wait_result("bp second");
    endtask

    task automatic test_clear_race();
        stub_apr      = 10'h100;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL clr grant: got %b want 0010", bus.req_ready);
        end
        exp_q.push_back(mk(1, 7'h15));
        tick();
        bus.ctx_clr = 4'b0010;
        tick();
        bus.ctx_clr = '0;
        wait_result("clr result");
        run_txn("clr reload", 4'b0010, 1, 7'h15, 1'b1, 12'h0, 14'h0, 10'h0);
        stub_apr = 10'h07F;
    endtask

    task automatic test_reset_mid();
        run_txn("rst prime", 4'b1000, 3, 7'h15, 1'b0, '0, '0, '0);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        vectors++;
        if (bus.req_ready !== 4'b1000 || bus.dp_ap !== 10'h07F) begin
            errors++;
            $display("FAIL rst prior ctx: req_ready=%b dp_ap=%h want 1000 07f", bus.req_ready, bus.dp_ap);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL rst mid: busy=%b res_valid=%b req_ready=%b want 0", busy, bus.res_valid, bus.req_ready);
        end
        run_txn("rst ch0 first", 4'b1001, 0, 7'h15, 1'b0, '0, '0, '0);
        run_txn("rst ctx3", 4'b1000, 3, 7'h15, 1'b1, 12'h0, 14'h0, 10'h0);
    endtask

    task automatic test_isolation();
        do_reset();
        stub_mode = 1;
        for (int n = 0; n < 4; n++) begin
            run_txn("iso ch0", 4'b0001, 0, 7'(2 * n), 1'b1, 12'(n), 14'(2 * n), 10'(16 * n));
            run_txn("iso ch1", 4'b0010, 1, 7'(2 * n), 1'b1, 12'(n), 14'(2 * n), 10'(16 * n));
        end
        stub_mode = 0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.ctx_clr   = '0;
        bus.res_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_clear_race();
        test_reset_mid();
        test_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/asc_chan_sched.md
Name: asc_chan_sched

Overview:
Multi-channel scheduler that time-shares one adaptive-speed-control update datapath (F(I), short/long-term filters, AX compare, AP filter/trigger, AL limiter) among NCH ADPCM channels. It holds the per-channel delayed state (DMS, DML, AP) in a context register file and arbitrates channel requests round-robin. It sequences each update through a fixed load/compute/store pipeline and returns AL with the channel tag. It sits between the per-channel codec front ends and a single combinational speed-control datapath.

Parameters:
NCH, 4, number of channels (2..16)
CHW, 2, channel index width, equal to ceil(log2(NCH))

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  NCH  per-channel update request
req_ready  out  NCH  one-hot accept pulse
req_data  in  NCH*22  per channel {I[4:0],Y[12:0],TDP,TR,RATE[1:0]}; channel k at bits [22k+21:22k]
ctx_clr  in  NCH  per-channel context clear
dp_i/dp_y/dp_tdp/dp_tr/dp_rate  out  5/13/1/1/2  registered operands to datapath
dp_dms/dp_dml/dp_ap  out  12/14/10  registered context to datapath
dp_dmsp/dp_dmlp/dp_apr  in  12/14/10  datapath next-state results (combinational)
dp_al  in  7  datapath limited AL, derived from dp_ap
res_valid  out  1  result available
res_ch  out  CHW  channel of result
res_al  out  7  AL for that channel
res_ready  in  1  result consumer accept
busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock domain (clk); reset synchronous, active-high; all outputs registered.
- Reset: FSM=IDLE; all contexts (DMS, DML, AP) = 0; rr_ptr=NCH-1, so ch0 wins first; all outputs 0; any in-flight update is discarded with no write-back.
- FSM IDLE -> LOAD -> CALC -> STORE -> DONE -> IDLE.
- IDLE: if any req_valid, grant the first set bit searching from rr_ptr+1, modulo NCH. Same cycle: req_ready[g]=1, latch req_data[g] and g, set rr_ptr=g, go LOAD. Otherwise remain in IDLE.
- LOAD: drive dp_* from latched request and ctx[g]; go CALC.
- CALC: dp_* held stable; sample dp_dmsp, dp_dmlp, dp_apr, dp_al at end of cycle; go STORE.
- STORE: ctx[g] <= {dmsp, dmlp, apr}; res_valid=1, res_ch=g, res_al=sampled dp_al; go DONE.
- DONE: hold res_* until res_valid && res_ready; then res_valid=0 next cycle, go IDLE. If res_ready is already high in STORE's following cycle, DONE lasts one cycle.
- Latency: accept at cycle 0, res_valid at cycle 3. Minimum issue interval 5 cycles.
- AL uses the pre-update AP, i.e. the delayed value, consistent with the single-channel pipeline.
- Fairness: a continuously requesting channel cannot be granted twice while another channel has req_valid high.
- req_ready is a single-cycle pulse. A requester holding req_valid after the pulse is a new request.
- ctx_clr[k] zeroes ctx[k] at the next edge, in any state.
- ctx_clr[g] asserted in LOAD/CALC/STORE for the in-flight channel: clear wins. The STORE write-back is suppressed and ctx[g] ends at 0. res_al is still returned from the sampled dp_al.
- ctx_clr has no effect on arbitration.
- Context widths are exact; no saturation in this block. The datapath owns arithmetic and limiting.

Test Plan:
- Reset then single request: ch2 req, I=5'h0F, datapath stub returns dmsp=12'h123, dmlp=14'h0456, apr=10'h07F, al=7'h15 -> req_ready=4'b0100 at cycle 0, res_valid at cycle 3 with res_ch=2, res_al=7'h15; next ch2 update shows dp_dms=12'h123, dp_dml=14'h0456, dp_ap=10'h07F in LOAD.
- Round-robin: all four req_valid held high continuously -> grant order 0,1,2,3,0,1; each grant spaced 5 cycles with res_ready tied high.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_valid, res_ch, res_al held constant; no new req_ready pulse; grant occurs in the cycle after acceptance returns to IDLE.
- Clear race: ch1 in CALC with stub apr=10'h100, ctx_clr[1]=1 -> res_valid still asserted; next ch1 LOAD shows dp_dms=0, dp_dml=0, dp_ap=0.
- Reset mid-operation: reset asserted in CALC for ch3 (prior ctx nonzero) -> next cycle busy=0, res_valid=0; ctx[3]=0; the following request from ch0 and ch3 together grants ch0.
- Context isolation: alternate ch0/ch1 with stub apr = dp_ap+10'd16 -> after 3 updates each, ch0 and ch1 dp_ap independently read 10'd48.
